dsa_simd_control_fsm: RTL
=========================

DSA_SIMD_CONTROL_FSM -- requirements
Module: dsa_simd_control_fsm

Interface
REQ-001 Parameter LANES, default 4, pixels issued per group (1..16).
REQ-002 Parameter COORD_W, default 16, coordinate/dimension width.
REQ-003 Parameter IMG_WIDTH_MAX, default 512, largest legal output width.
REQ-004 Parameter IMG_HEIGHT_MAX, default 512, largest legal output height.
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 enable  in  1  level; rising use starts a frame; drop returns from DONE/ERROR to IDLE.
REQ-008 abort  in  1  cancel the current frame.
REQ-009 step_mode  in  1  pause after every group until step_go.
REQ-010 step_go  in  1  single-cycle release in step mode.
REQ-011 img_width_out / img_height_out  in  COORD_W each  output image dimensions.
REQ-012 fetch_req  out  1  one-cycle fetch request for the current group.
REQ-013 fetch_done  in  1  fetch complete.
REQ-014 dp_start  out  1  one-cycle datapath start pulse.
REQ-015 dp_done  in  1  datapath complete.
REQ-016 write_enable  out  1  one-cycle write strobe.
REQ-017 lane_valid  out  LANES  bit i set when lane i holds a real pixel.
REQ-018 current_x / current_y  out  COORD_W each  coordinate of lane 0.
REQ-019 pixels_processed  out  32  count of valid pixels written this frame.
REQ-020 busy / ready / error  out  1 each  running / frame done / illegal dimensions.

Function
REQ-021 States: IDLE, INIT, REQ_FETCH, WAIT_FETCH, START_DP, WAIT_DP, WRITE, NEXT_GROUP, STEP_WAIT, DONE, ERROR.
REQ-022 IDLE->INIT when enable=1. INIT latches dimensions, clears x, y and the count; later dimension changes are ignored.
REQ-023 INIT->ERROR if width or height is 0, width>IMG_WIDTH_MAX or height>IMG_HEIGHT_MAX; otherwise INIT->REQ_FETCH.
REQ-024 REQ_FETCH asserts fetch_req for exactly one cycle, ->WAIT_FETCH; WAIT_FETCH holds until fetch_done=1, ->START_DP.
REQ-025 START_DP asserts dp_start for exactly one cycle, ->WAIT_DP; WAIT_DP holds until dp_done=1, ->WRITE. A dp_done in START_DP is ignored.
REQ-026 WRITE asserts write_enable for one cycle, ->NEXT_GROUP.
REQ-027 lane_valid[i] = (x+i < width_latched), held stable REQ_FETCH through WRITE; groups never span rows, so the last group of a row is partial.
REQ-028 NEXT_GROUP: pixels_processed += popcount(lane_valid); if x+LANES < width then x += LANES, else x=0 and y += 1.
REQ-029 NEXT_GROUP->DONE when the group was the last one (y=height-1 and x+LANES>=width); otherwise ->STEP_WAIT if step_mode=1, else ->REQ_FETCH.
REQ-030 STEP_WAIT->REQ_FETCH on step_go=1, or immediately if step_mode has dropped.
REQ-031 DONE and ERROR hold until enable=0, then ->IDLE; a frame does not restart while enable is held high.
REQ-032 abort=1 in any state other than IDLE/DONE/ERROR: ->IDLE next cycle, no further strobes; count and coordinates freeze.
REQ-033 abort has priority over fetch_done, dp_done and step_go arriving in the same cycle.
REQ-034 busy=1 outside IDLE/DONE/ERROR; ready=1 only in DONE; error=1 only in ERROR.
REQ-035 Coordinate arithmetic is COORD_W+1 bits wide so x+LANES cannot wrap; the count saturates at 2^32-1.
REQ-036 All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

Reset
REQ-037 rst forces IDLE. Strobes, lane_valid, busy, ready and error reset to 0; x, y, latched dimensions and pixels_processed reset to 0.
REQ-038 rst mid-frame abandons the frame immediately; the first post-reset cycle issues no strobe.

Structure
REQ-039 Package dsa_ctrl_pkg holds state_t and the lane-count limit constant.
REQ-040 Sub-module dsa_lane_mask (inputs x, width; outputs lane_valid, popcount) is combinational and instantiated once.

Verification
REQ-041 LANES=4, 8x2, handshakes answered next cycle -> 4 groups, lane_valid=1111 each; (x,y) sequence (0,0),(4,0),(0,1),(4,1); pixels_processed=16; ready=1.
REQ-042 LANES=4, 6x1 -> groups at x=0 (1111) and x=4 (0011); pixels_processed=6; exactly 2 write_enable pulses.
REQ-043 width=0 or width=513 with enable=1 -> ERROR, error=1, no fetch_req; enable=0 -> IDLE, error=0.
REQ-044 8x8, abort on the cycle dp_done arrives in the 3rd group -> IDLE next cycle, no write_enable, pixels_processed=8, busy=0.
REQ-045 step_mode=1, 8x1 -> STEP_WAIT after group 1, no fetch_req until step_go pulses; then group 2 completes; DONE.
REQ-046 fetch_done delayed 10 cycles and dp_done 5 cycles -> fetch_req and dp_start remain one-cycle pulses; no state advance before each done.

Source files
------------

// File: rtl/dsa_ctrl_pkg.sv
// Shared types and limits for the SIMD pixel-group control FSM.
// Imported by the control FSM and its lane-mask helper.
package dsa_ctrl_pkg;

    localparam int LANES_MAX = 16;
    localparam int POP_W     = $clog2(LANES_MAX + 1);

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        REQ_FETCH,
        WAIT_FETCH,
        START_DP,
        WAIT_DP,
        WRITE,
        NEXT_GROUP,
        STEP_WAIT,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/dsa_lane_mask.sv
// Per-lane validity for a pixel group starting at x within a row of width.
// Purely combinational; also returns the number of valid lanes.
module dsa_lane_mask
    import dsa_ctrl_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int COORD_W = 16
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] width,
    output logic [LANES-1:0]   lane_valid,
    output logic [POP_W-1:0]   popcount
);

    localparam int CW = COORD_W + 1;

    always_comb begin
        lane_valid = '0;
        popcount   = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_valid[i] = ({1'b0, x} + CW'(i)) < {1'b0, width};
            popcount      = popcount + POP_W'(lane_valid[i]);
        end
    end

endmodule

// File: rtl/dsa_simd_control_fsm.sv
// Frame sequencer: walks the output image in LANES-wide groups, driving
// fetch / datapath / write handshakes per group, with step and abort.
module dsa_simd_control_fsm
    import dsa_ctrl_pkg::*;
#(
    parameter int LANES          = 4,
    parameter int COORD_W        = 16,
    parameter int IMG_WIDTH_MAX  = 512,
    parameter int IMG_HEIGHT_MAX = 512
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               abort,
    input  logic               step_mode,
    input  logic               step_go,
    input  logic [COORD_W-1:0] img_width_out,
    input  logic [COORD_W-1:0] img_height_out,
    output logic               fetch_req,
    input  logic               fetch_done,
    output logic               dp_start,
    input  logic               dp_done,
    output logic               write_enable,
    output logic [LANES-1:0]   lane_valid,
    output logic [COORD_W-1:0] current_x,
    output logic [COORD_W-1:0] current_y,
    output logic [31:0]        pixels_processed,
    output logic               busy,
    output logic               ready,
    output logic               error
);

    localparam int CW = COORD_W + 1;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [COORD_W-1:0] w_q, w_d;
    logic [COORD_W-1:0] h_q, h_d;
    logic [31:0]        cnt_q, cnt_d;

    logic [LANES-1:0]   mask;
    logic [POP_W-1:0]   pop;
    logic [CW-1:0]      x_nxt;
    logic [32:0]        cnt_sum;
    logic [31:0]        cnt_sat;
    logic               row_end;
    logic               last_grp;
    logic               dims_bad;
    logic               in_grp;
    logic               running;

    dsa_lane_mask #(
        .LANES   (LANES),
        .COORD_W (COORD_W)
    ) u_lane_mask (
        .x          (x_q),
        .width      (w_q),
        .lane_valid (mask),
        .popcount   (pop)
    );

    // One extra bit keeps x+LANES from wrapping near the top of the range.
    assign x_nxt    = {1'b0, x_q} + CW'(LANES);
    assign row_end  = x_nxt >= {1'b0, w_q};
    assign last_grp = row_end && (({1'b0, y_q} + CW'(1)) >= {1'b0, h_q});

    assign dims_bad = (w_q == '0) || (h_q == '0)
                   || ({1'b0, w_q} > CW'(IMG_WIDTH_MAX))
                   || ({1'b0, h_q} > CW'(IMG_HEIGHT_MAX));

    assign cnt_sum = {1'b0, cnt_q} + 33'(pop);
    assign cnt_sat = cnt_sum[32] ? '1 : cnt_sum[31:0];

    assign running = (state_q != IDLE) && (state_q != DONE)
                  && (state_q != ERROR);

    assign in_grp = (state_q == REQ_FETCH) || (state_q == WAIT_FETCH)
                 || (state_q == START_DP)  || (state_q == WAIT_DP)
                 || (state_q == WRITE);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = INIT;
                    w_d     = img_width_out;
                    h_d     = img_height_out;
                    x_d     = '0;
                    y_d     = '0;
                    cnt_d   = '0;
                end
            end
            INIT:       state_d = dims_bad ? ERROR : REQ_FETCH;
            REQ_FETCH:  state_d = WAIT_FETCH;
            WAIT_FETCH: if (fetch_done) state_d = START_DP;
            START_DP:   state_d = WAIT_DP;
            WAIT_DP:    if (dp_done) state_d = WRITE;
            WRITE:      state_d = NEXT_GROUP;
            NEXT_GROUP: begin
                cnt_d = cnt_sat;
                if (row_end) begin
                    x_d = '0;
                    y_d = y_q + COORD_W'(1);
                end else begin
                    x_d = x_nxt[COORD_W-1:0];
                end
                if (last_grp)       state_d = DONE;
                else if (step_mode) state_d = STEP_WAIT;
                else                state_d = REQ_FETCH;
            end
            STEP_WAIT: begin
                if (step_go || !step_mode) state_d = REQ_FETCH;
            end
            DONE, ERROR: if (!enable) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
        // Abort wins over any handshake in the same cycle and freezes progress.
        if (abort && running) begin
            state_d = IDLE;
            x_d     = x_q;
            y_d     = y_q;
            cnt_d   = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fetch_req        = (state_q == REQ_FETCH);
    assign dp_start         = (state_q == START_DP);
    assign write_enable     = (state_q == WRITE);
    assign lane_valid       = in_grp ? mask : '0;
    assign current_x        = x_q;
    assign current_y        = y_q;
    assign pixels_processed = cnt_q;
    assign busy             = running;
    assign ready            = (state_q == DONE);
    assign error            = (state_q == ERROR);

endmodule
